// File: rtl/g15_io_pkg.sv
// Shared types and tape-code constants for the G-15 I/O character path.
package g15_io_pkg;

    typedef logic [4:0] oa_code_t;

    localparam oa_code_t CODE_STOP   = 5'b10000;
    localparam oa_code_t CODE_CR     = 5'b10001;
    localparam oa_code_t CODE_TAB    = 5'b10010;
    localparam oa_code_t CODE_MINUS  = 5'b10100;
    localparam oa_code_t CODE_PERIOD = 5'b10101;
    localparam oa_code_t CODE_WAIT   = 5'b10110;
    localparam oa_code_t CODE_RELOAD = 5'b10111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        HOLD   = 2'd2,
        RETIRE = 2'd3
    } feed_state_t;

endpackage

// File: rtl/io_char_fifo.sv
// Character FIFO, DEPTH x 5 bits, with occupancy count; pointers wrap modulo DEPTH.
module io_char_fifo
    import g15_io_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [4:0]               push_data,
    input  logic                     pop,
    output logic [4:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    oa_code_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/io_oa_feed.sv
// Host-to-OA character feeder aligned to drum word timing.
// Optional odd-parity checking on host_data[5] is enabled by defining G15_IN_PARITY_EN.
module io_oa_feed
    import g15_io_pkg::*;
#(
    parameter int       DEPTH     = 4,
    parameter logic [4:0] STOP_CODE = CODE_STOP
) (
    input  logic                   CLOCK,
    input  logic                   rst,
    input  logic                   T0,
    input  logic                   T29,
    input  logic                   IN,
    input  logic                   OA_TAKE,
    input  logic [5:0]             host_data,
    input  logic                   host_valid,
    output logic                   host_ready,
    output logic                   OA1,
    output logic                   OA2,
    output logic                   OA3,
    output logic                   OA4,
    output logic                   OA5,
    output logic                   CHAR_RDY,
    output logic                   IN_STOP,
    output logic [$clog2(DEPTH):0] FIFO_CNT,
    output logic                   PAR_ERR
);

    feed_state_t state_q, state_d;
    oa_code_t    oa_q, oa_d;
    logic        rdy_q, rdy_d;
    logic        stop_q, stop_d;
    logic        seen_q, seen_d;
    logic        pend_q, pend_d;
    logic        pop;
    logic        wr_en;
    logic        par_ok;
    logic        fifo_full;
    logic        fifo_empty;
    oa_code_t    fifo_head;

`ifdef G15_IN_PARITY_EN
    logic in_d;
    logic par_err_q;

    assign par_ok = ^host_data;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            in_d      <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            in_d <= IN;
            if (in_d && !IN)
                par_err_q <= 1'b0;
            else if (host_valid && host_ready && !par_ok)
                par_err_q <= 1'b1;
        end
    end

    assign PAR_ERR = par_err_q;
`else
    logic unused_par;

    assign par_ok     = 1'b1;
    assign unused_par = host_data[5];
    assign PAR_ERR    = 1'b0;
`endif

    assign host_ready = ~fifo_full;
    assign wr_en      = host_valid & host_ready & par_ok;

    io_char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLOCK),
        .rst       (rst),
        .push      (wr_en),
        .push_data (host_data[4:0]),
        .pop       (pop),
        .head      (fifo_head),
        .count     (FIFO_CNT),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q <= IDLE;
            oa_q    <= '0;
            rdy_q   <= 1'b0;
            stop_q  <= 1'b0;
            seen_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            oa_q    <= oa_d;
            rdy_q   <= rdy_d;
            stop_q  <= stop_d;
            seen_q  <= seen_d;
            pend_q  <= pend_d;
        end
    end

    // pend_q remembers whether the retired character was the stop code, since
    // OA may already be cleared when retirement completes.
    always_comb begin
        state_d = state_q;
        oa_d    = oa_q;
        rdy_d   = rdy_q;
        stop_d  = stop_q;
        seen_d  = seen_q;
        pend_d  = pend_q;
        pop     = 1'b0;
        if (!IN) begin
            state_d = IDLE;
            oa_d    = '0;
            rdy_d   = 1'b0;
            stop_d  = 1'b0;
            seen_d  = 1'b0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty && !stop_q) state_d = ALIGN;
                end
                ALIGN: begin
                    if (T0 && !fifo_empty) begin
                        pop     = 1'b1;
                        oa_d    = fifo_head;
                        rdy_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (OA_TAKE) begin
                        rdy_d   = 1'b0;
                        pend_d  = (oa_q == STOP_CODE);
                        state_d = RETIRE;
                        if (T29) begin
                            seen_d = 1'b1;
                            oa_d   = '0;
                        end
                    end
                end
                RETIRE: begin
                    // After a take coincident with T29 this cycle is already T0,
                    // so the next character loads here rather than a word later.
                    if (seen_q) begin
                        seen_d = 1'b0;
                        if (pend_q) begin
                            stop_d  = 1'b1;
                            state_d = IDLE;
                        end else if (T0 && !fifo_empty) begin
                            pop     = 1'b1;
                            oa_d    = fifo_head;
                            rdy_d   = 1'b1;
                            state_d = HOLD;
                        end else begin
                            state_d = ALIGN;
                        end
                    end else if (T29) begin
                        oa_d = '0;
                        if (pend_q) begin
                            stop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = ALIGN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign {OA5, OA4, OA3, OA2, OA1} = oa_q;
    assign CHAR_RDY = rdy_q;
    assign IN_STOP  = stop_q;

endmodule

// File: tb/tb_io_oa_feed.sv
// Directed bench for io_oa_feed: word timing, ordering, stop handling, coincident take, reset and parity.
module tb_io_oa_feed;

    localparam int DEPTH = 4;

    logic       CLOCK = 1'b0;
    logic       rst;
    logic       T0;
    logic       T29;
    logic       IN;
    logic       OA_TAKE;
    logic [5:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic       OA1, OA2, OA3, OA4, OA5;
    logic       CHAR_RDY;
    logic       IN_STOP;
    logic [2:0] FIFO_CNT;
    logic       PAR_ERR;

    logic [4:0] oa_bus;
    int         wc = 0;
    int         n_chk = 0;
    int         n_err = 0;

    io_oa_feed #(.DEPTH(DEPTH), .STOP_CODE(5'b10000)) dut (
        .CLOCK      (CLOCK),
        .rst        (rst),
        .T0         (T0),
        .T29        (T29),
        .IN         (IN),
        .OA_TAKE    (OA_TAKE),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .OA1        (OA1),
        .OA2        (OA2),
        .OA3        (OA3),
        .OA4        (OA4),
        .OA5        (OA5),
        .CHAR_RDY   (CHAR_RDY),
        .IN_STOP    (IN_STOP),
        .FIFO_CNT   (FIFO_CNT),
        .PAR_ERR    (PAR_ERR)
    );

    always #5 CLOCK = ~CLOCK;

    // 30-cycle drum word; T0 and T29 mark its first and last cycles.
    always @(posedge CLOCK) wc <= (wc == 29) ? 0 : wc + 1;
    assign T0     = (wc == 0);
    assign T29    = (wc == 29);
    assign oa_bus = {OA5, OA4, OA3, OA2, OA1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK);
    endtask

    task automatic wait_wc(input int n);
        int guard = 0;
        while (wc != n && guard < 64) begin
            tick();
            guard++;
        end
        if (wc != n) chk("wc_timeout", 32'(wc), 32'(n));
    endtask

    task automatic wait_rdy(input string tag);
        int guard = 0;
        while (!CHAR_RDY && guard < 120) begin
            tick();
            guard++;
        end
        if (!CHAR_RDY) chk(tag, 32'(CHAR_RDY), 32'h1);
    endtask

    task automatic push(input logic [4:0] c);
        host_data  = {~^c, c};
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic push_raw(input logic [5:0] d);
        host_data  = d;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic take();
        OA_TAKE = 1'b1;
        tick();
        OA_TAKE = 1'b0;
    endtask

    logic [4:0] codes [5];

    initial begin
        rst = 1'b1; IN = 1'b0; OA_TAKE = 1'b0; host_data = '0; host_valid = 1'b0;
        codes[0] = 5'h01; codes[1] = 5'h02; codes[2] = 5'h04; codes[3] = 5'h09; codes[4] = 5'h0C;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_oa", 32'(oa_bus), 32'h0);
        chk("rst_rdy", 32'(CHAR_RDY), 32'h0);
        chk("rst_cnt", 32'(FIFO_CNT), 32'h0);
        chk("rst_hrdy", 32'(host_ready), 32'h1);
        chk("rst_stop", 32'(IN_STOP), 32'h0);
        chk("rst_par", 32'(PAR_ERR), 32'h0);

        // Single character: push at word cycle 10, load at the next T0.
        IN = 1'b1;
        wait_wc(10);
        push(5'h03);
        chk("one_cnt", 32'(FIFO_CNT), 32'h1);
        wait_wc(0);
        chk("one_pre_rdy", 32'(CHAR_RDY), 32'h0);
        chk("one_pre_oa", 32'(oa_bus), 32'h0);
        tick();
        chk("one_oa", 32'(oa_bus), 32'h03);
        chk("one_rdy", 32'(CHAR_RDY), 32'h1);
        chk("one_cnt0", 32'(FIFO_CNT), 32'h0);
        wait_wc(5);
        take();
        chk("one_rdy_drop", 32'(CHAR_RDY), 32'h0);
        chk("one_oa_held", 32'(oa_bus), 32'h03);
        wait_wc(29);
        chk("one_oa_t29", 32'(oa_bus), 32'h03);
        tick();
        chk("one_oa_clr", 32'(oa_bus), 32'h0);

        // Fill with IN low, then drain in order at one character per word.
        IN = 1'b0;
        tick();
        host_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            host_data = {~^codes[i], codes[i]};
            tick();
            if (i == DEPTH - 1) begin
                chk("fill_hrdy", 32'(host_ready), 32'h0);
                chk("fill_cnt", 32'(FIFO_CNT), 32'(DEPTH));
            end
        end
        host_valid = 1'b0;
        chk("fill_cnt_after", 32'(FIFO_CNT), 32'(DEPTH));
        chk("fill_rdy_in0", 32'(CHAR_RDY), 32'h0);
        IN = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_rdy("drain_timeout");
            chk("drain_oa", 32'(oa_bus), 32'(codes[i]));
            chk("drain_wc", 32'(wc), 32'h1);
            take();
        end
        wait_wc(0);
        tick();
        chk("drain_empty", 32'(FIFO_CNT), 32'h0);
        chk("drain_hrdy", 32'(host_ready), 32'h1);

        // Stop code ends the block; the following code stays queued.
        push(5'h07);
        push(5'h10);
        push(5'h02);
        wait_rdy("stop_t1");
        chk("stop_first", 32'(oa_bus), 32'h07);
        take();
        wait_rdy("stop_t2");
        chk("stop_code", 32'(oa_bus), 32'h10);
        chk("stop_pre", 32'(IN_STOP), 32'h0);
        take();
        wait_wc(29);
        tick();
        chk("stop_set", 32'(IN_STOP), 32'h1);
        chk("stop_cnt", 32'(FIFO_CNT), 32'h1);
        chk("stop_oa", 32'(oa_bus), 32'h0);
        repeat (40) tick();
        chk("stop_blocked", 32'(CHAR_RDY), 32'h0);
        IN = 1'b0;
        tick();
        chk("stop_clr", 32'(IN_STOP), 32'h0);
        IN = 1'b1;
        wait_rdy("stop_resume");
        chk("stop_next", 32'(oa_bus), 32'h02);
        chk("stop_next_wc", 32'(wc), 32'h1);

        // Take coincident with T29: clear next cycle, next code at the following T0.
        push(5'h0B);
        wait_wc(29);
        take();
        chk("co_oa_clr", 32'(oa_bus), 32'h0);
        chk("co_rdy", 32'(CHAR_RDY), 32'h0);
        tick();
        chk("co_oa_next", 32'(oa_bus), 32'h0B);
        chk("co_rdy_next", 32'(CHAR_RDY), 32'h1);

        // IN falling mid-HOLD discards OA but keeps the queue.
        push(5'h0A);
        IN = 1'b0;
        tick();
        chk("fall_oa", 32'(oa_bus), 32'h0);
        chk("fall_rdy", 32'(CHAR_RDY), 32'h0);
        chk("fall_cnt", 32'(FIFO_CNT), 32'h1);
        IN = 1'b1;
        wait_rdy("fall_resume");
        chk("fall_next", 32'(oa_bus), 32'h0A);

        // Reset while holding a character with the queue non-empty.
        push(5'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_oa", 32'(oa_bus), 32'h0);
        chk("mrst_rdy", 32'(CHAR_RDY), 32'h0);
        chk("mrst_cnt", 32'(FIFO_CNT), 32'h0);
        chk("mrst_hrdy", 32'(host_ready), 32'h1);

        IN = 1'b0;
        tick();
`ifdef G15_IN_PARITY_EN
        push_raw(6'b0_00011);
        chk("par_err", 32'(PAR_ERR), 32'h1);
        chk("par_drop", 32'(FIFO_CNT), 32'h0);
        chk("par_hrdy", 32'(host_ready), 32'h1);
        push_raw(6'b1_00011);
        chk("par_ok_cnt", 32'(FIFO_CNT), 32'h1);
        chk("par_sticky", 32'(PAR_ERR), 32'h1);
`else
        push_raw(6'b0_00011);
        chk("nopar_cnt", 32'(FIFO_CNT), 32'h1);
        chk("nopar_err", 32'(PAR_ERR), 32'h0);
        push_raw(6'b1_00101);
        chk("nopar_cnt2", 32'(FIFO_CNT), 32'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_oa_feed.md
Name: io_oa_feed

Overview:
- Input-side feeder for the I/O character register OA (OA1..OA5).
- The insertion and marker logic for MZ/M19/M23 consumes OA1/OA4. This block is the producing end: it accepts 5-bit tape/typewriter codes from the host device emulation, buffers them, and presents them on OA aligned to drum word timing.
- It raises a character-ready request and retires each character on the consumer's take pulse.

Parameters:
- DEPTH, 4, host FIFO depth in characters; power of two, at least 2.
- STOP_CODE, 5'b10000, tape code that ends a block; it asserts IN_STOP.

Ports:
- CLOCK  in  1  system clock
- rst  in  1  synchronous active-high reset
- T0  in  1  word-time 0 pulse, one cycle per word
- T29  in  1  word-time 29 pulse, one cycle per word
- IN  in  1  input mode active; the feeder presents characters only while IN=1
- OA_TAKE  in  1  one-cycle pulse: consumer has inserted the current OA character
- host_data  in  6  [4:0] code; [5] odd-parity bit, used only with the option
- host_valid  in  1  host offers host_data
- host_ready  out  1  FIFO can accept; a transfer occurs when valid & ready
- OA1, OA2, OA3, OA4, OA5  out  1 each  presented character bits [0]..[4]
- CHAR_RDY  out  1  OA holds a valid character awaiting OA_TAKE
- IN_STOP  out  1  stop code reached; sticky until IN falls or reset
- FIFO_CNT  out  $clog2(DEPTH)+1  occupancy
- PAR_ERR  out  1  sticky parity error (tied 0 without the option)

Behaviour:
- Reset (synchronous, any state): FIFO empty, FSM IDLE, OA=0, CHAR_RDY=0, IN_STOP=0, PAR_ERR=0, host_ready=1.
- FIFO: host_ready = (FIFO_CNT<DEPTH).
  - Write on host_valid & host_ready.
  - A simultaneous write and pop in one cycle leaves FIFO_CNT unchanged.
  - Read/write pointers wrap modulo DEPTH.
  - Pushes are accepted in any FSM state, including while IN=0.
- FSM states and transitions:
  - IDLE: if IN & FIFO non-empty & ~IN_STOP, go to ALIGN.
  - ALIGN: on T0, pop the FIFO head into OA[4:0], set CHAR_RDY, go to HOLD. The load therefore happens in the T0 cycle, so OA is stable from T1. If the FIFO is empty, OA is never loaded mid-word.
  - HOLD: OA and CHAR_RDY are held. On OA_TAKE go to RETIRE. If OA_TAKE and T29 coincide, RETIRE is entered and T29 is treated as already seen.
  - RETIRE:
    - CHAR_RDY drops the cycle after OA_TAKE.
    - OA is held until T29, then cleared to 0 in the following cycle.
    - If the retired code equals STOP_CODE, IN_STOP sets and the FSM goes to IDLE.
    - Otherwise the FSM goes to ALIGN, so the next character loads no earlier than the next T0 (minimum one character per word).
- OA_TAKE outside HOLD is ignored.
- IN falling in any state: go to IDLE at the next cycle, clear OA, CHAR_RDY and IN_STOP. The un-taken OA character is discarded; FIFO contents are kept.
- IN_STOP=1 blocks leaving IDLE until IN cycles low.

Optional Feature:
- Macro: G15_IN_PARITY_EN.
- With the macro defined:
  - host_data[5] is odd parity over [5:0].
  - On a write with even parity, PAR_ERR sets (sticky until reset or IN falling) and the character is dropped, not written.
  - host_ready is unaffected.
- Without the macro: host_data[5] is ignored, PAR_ERR is tied 0, and all characters are written.

Decomposition:
- Shared package g15_io_pkg:
  - oa_code_t (5-bit);
  - tape code constants (STOP, CR, TAB, MINUS, RELOAD, WAIT, PERIOD);
  - FSM enum feed_state_t {IDLE, ALIGN, HOLD, RETIRE}.
- One natural sub-module: io_char_fifo (parameterised DEPTH×5, synchronous reset, push/pop/count). The FSM and OA register stay in io_oa_feed.

Test Plan:
- Reset mid-HOLD with a character on OA → the next cycle shows OA=0, CHAR_RDY=0, FIFO_CNT=0, host_ready=1.
- IN=1, push 5'h03 at word cycle 10 → OA loads exactly at the next T0, CHAR_RDY=1 from that cycle; OA_TAKE at T5 → CHAR_RDY=0 at T6, OA=0 the cycle after T29.
- Push DEPTH+1 codes with IN=0 → host_ready=0 after DEPTH writes, FIFO_CNT=DEPTH; raise IN and take each → codes emerge in order, one per word at most.
- Push 5'h07, STOP_CODE, 5'h02; take each → IN_STOP sets after STOP retires and 5'h02 stays queued (FIFO_CNT=1); drop and raise IN → 5'h02 presented at the next T0.
- OA_TAKE coincident with T29 in HOLD → OA clears the next cycle; the next character loads at the immediately following T0.
- With G15_IN_PARITY_EN: push 6'b0_00011 (even parity) → PAR_ERR=1, FIFO_CNT unchanged; push 6'b1_00011 → accepted.
